// File: rtl/audio_meter_pkg.sv
// Shared constants and the peak-to-level quantiser for the audio level meter.
package audio_meter_pkg;
  localparam int MIC_MIDPOINT = 2048;
  localparam int AMP_W        = 11;
  localparam int NUM_LEDS     = 9;
  localparam int LEVEL_W      = 4;
  localparam logic [AMP_W-1:0] AMP_MAX = '1;

  // Number of thresholds k*step (k = 1..NUM_LEDS) that the peak reaches.
  function automatic logic [LEVEL_W-1:0] peak_to_level(input logic [AMP_W-1:0] peak,
                                                       input int step);
    logic [LEVEL_W-1:0] lvl;
    lvl = '0;
    for (int k = 1; k <= NUM_LEDS; k++)
      if (int'(peak) >= k * step) lvl = LEVEL_W'(k);
    return lvl;
  endfunction
endpackage

// File: rtl/level_to_bar.sv
// Combinational level (0..9) to thermometer bar: bits [level-1:0] set.
module level_to_bar
  import audio_meter_pkg::*;
(
  input  logic [LEVEL_W-1:0]  level,
  output logic [NUM_LEDS-1:0] bar
);
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_bit
    assign bar[gi] = (level > LEVEL_W'(gi));
  end
endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak meter: mic samples -> 0..9 level and 9-LED bar, updated once per window.
// Define AUDIO_METER_PEAK_HOLD_EN to add a decaying peak-hold dot on the bar.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W       = 12,
  parameter int WINDOW_SAMPLES = 4000,
  parameter int STEP           = 200
`ifdef AUDIO_METER_PEAK_HOLD_EN
  , parameter int HOLD_WINDOWS = 3
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  output logic [NUM_LEDS-1:0] led_bar,
  output logic [LEVEL_W-1:0]  level,
  output logic                window_done
);
  localparam int CNT_W = $clog2(WINDOW_SAMPLES);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIC_MIDPOINT);

  logic [AMP_W-1:0]    amp, peak_max, peak_reg, peak_latched_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                latch_valid_reg, window_done_reg;
  logic [LEVEL_W-1:0]  level_next, level_reg;
  logic [NUM_LEDS-1:0] level_bar, bar_next, led_bar_reg;

  // Full negative swing (mic_in = 0) would be 2048; clamp to the 11-bit range.
  always_comb begin
    if (mic_in >= MID)
      amp = AMP_W'(mic_in - MID);
    else if ((MID - mic_in) > SAMPLE_W'(AMP_MAX))
      amp = AMP_MAX;
    else
      amp = AMP_W'(MID - mic_in);
  end

  assign peak_max   = (amp > peak_reg) ? amp : peak_reg;
  assign level_next = peak_to_level(peak_latched_reg, STEP);

  level_to_bar u_level_bar (.level(level_next), .bar(level_bar));

`ifdef AUDIO_METER_PEAK_HOLD_EN
  localparam int HOLD_CNT_W = $clog2(HOLD_WINDOWS + 1);

  logic [LEVEL_W-1:0]    hold_level_reg, hold_level_next;
  logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [NUM_LEDS-1:0]   hold_therm;

  always_comb begin
    hold_level_next = hold_level_reg;
    hold_cnt_next   = hold_cnt_reg;
    if (level_next >= hold_level_reg) begin
      hold_level_next = level_next;
      hold_cnt_next   = HOLD_CNT_W'(HOLD_WINDOWS);
    end else if (hold_cnt_reg != '0) begin
      hold_cnt_next = hold_cnt_reg - HOLD_CNT_W'(1);
    end else if (hold_level_reg != '0) begin
      hold_level_next = hold_level_reg - LEVEL_W'(1);
    end
  end

  // The top bit of the hold thermometer is the single peak dot.
  level_to_bar u_hold_bar (.level(hold_level_next), .bar(hold_therm));
  assign bar_next = level_bar | (hold_therm ^ (hold_therm >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_level_reg <= '0;
      hold_cnt_reg   <= '0;
    end else if (latch_valid_reg) begin
      hold_level_reg <= hold_level_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end
`else
  assign bar_next = level_bar;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg        <= '0;
      peak_reg         <= '0;
      peak_latched_reg <= '0;
      latch_valid_reg  <= 1'b0;
      window_done_reg  <= 1'b0;
      level_reg        <= '0;
      led_bar_reg      <= '0;
    end else begin
      latch_valid_reg <= 1'b0;
      window_done_reg <= latch_valid_reg;
      if (sample_valid) begin
        if (count_reg == CNT_W'(WINDOW_SAMPLES - 1)) begin
          // Closing sample belongs to the window being latched.
          peak_latched_reg <= peak_max;
          peak_reg         <= '0;
          count_reg        <= '0;
          latch_valid_reg  <= 1'b1;
        end else begin
          peak_reg  <= peak_max;
          count_reg <= count_reg + CNT_W'(1);
        end
      end
      if (latch_valid_reg) begin
        level_reg   <= level_next;
        led_bar_reg <= bar_next;
      end
    end
  end

  assign led_bar     = led_bar_reg;
  assign level       = level_reg;
  assign window_done = window_done_reg;
endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: expected window results queued at the closing strobe.
module tb_audio_level_meter;
  import audio_meter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [8:0]  led_bar;
  logic [3:0]  level;
  logic        window_done;

  audio_level_meter dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .mic_in(mic_in),
    .led_bar(led_bar), .level(level), .window_done(window_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int lvl;
    int bar;
    int due;
  } exp_t;
  exp_t sb[$];

  int hold_lvl = 0;
  int hold_cnt = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, want, want, cyc);
    end
  endtask

  function automatic int amp_of(input int m);
    if (m >= 2048) return m - 2048;
    return (2048 - m > 2047) ? 2047 : 2048 - m;
  endfunction

  function automatic int level_of(input int peak);
    int l = 0;
    for (int k = 1; k <= 9; k++)
      if (peak >= k * 200) l = k;
    return l;
  endfunction

  function automatic int therm(input int l);
    return (1 << l) - 1;
  endfunction

  // Drives one full window; one non-silent sample at spike_pos, optional idle gaps with junk data.
  task automatic drive_window(input int spike_pos, input int spike_val, input bit gap);
    int peak = 0;
    int m, lvl, bar;
    exp_t e;
    for (int i = 0; i < 4000; i++) begin
      m = (i == spike_pos) ? spike_val : 2048;
      if (amp_of(m) > peak) peak = amp_of(m);
      if (gap && (i % 2 == 1)) begin
        @(negedge clk);
        sample_valid = 1'b0;
        mic_in = 12'd0;
      end
      @(negedge clk);
      sample_valid = 1'b1;
      mic_in = 12'(m);
    end
    @(posedge clk);
    #1;
    lvl = level_of(peak);
    bar = therm(lvl);
`ifdef AUDIO_METER_PEAK_HOLD_EN
    if (lvl >= hold_lvl) begin
      hold_lvl = lvl;
      hold_cnt = 3;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
    end else if (hold_lvl > 0) begin
      hold_lvl--;
    end
    if (hold_lvl > 0) bar = bar | (1 << (hold_lvl - 1));
`endif
    e.lvl = lvl;
    e.bar = bar;
    e.due = cyc + 1;
    sb.push_back(e);
    $display("window queued: peak=%0d level=%0d bar=%09b due=%0d", peak, lvl, bar[8:0], e.due);
    @(negedge clk);
    sample_valid = 1'b0;
    mic_in = 12'd2048;
  endtask

  // Monitor: compares every window_done against the scoreboard and times out late ones.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (window_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("level", int'(level), e.lvl);
          check("led_bar", int'(led_bar), e.bar);
          check("done_cycle", cyc, e.due);
          $display("window done: level=%0d led_bar=%09b cycle=%0d", level, led_bar, cyc);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check("done_timeout", cyc, e.due);
      end
    end
  end

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    mic_in = 12'd2048;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", int'(level), 0);
    check("reset_bar", int'(led_bar), 0);
    check("reset_done", int'(window_done), 0);
    @(negedge clk);
    rst = 1'b0;

    drive_window(-1, 2048, 1'b0);   // silence
    drive_window(1234, 2498, 1'b0); // amp 450 -> level 2
    drive_window(-1, 2048, 1'b0);   // back to silence
    drive_window(77, 0, 1'b0);      // saturating negative full scale
    drive_window(3000, 4095, 1'b0); // positive full scale
    drive_window(500, 3848, 1'b0);  // peak exactly 1800
    drive_window(500, 249, 1'b0);   // peak 1799
    drive_window(10, 2648, 1'b1);   // idle gaps carry mic_in=0, must be ignored
    drive_window(3999, 3048, 1'b0); // spike on the closing strobe -> level 5

    // Partial window with a full-scale spike, then reset: the spike must be discarded.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      mic_in = (i == 100) ? 12'd0 : 12'd2048;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_level", int'(level), 0);
    check("midreset_bar", int'(led_bar), 0);
    check("midreset_done", int'(window_done), 0);
    hold_lvl = 0;
    hold_cnt = 0;
    @(negedge clk);
    rst = 1'b0;

    drive_window(-1, 2048, 1'b0);   // first full window after reset
    drive_window(20, 0, 1'b0);      // level 9, then decay sequence
    for (int w = 0; w < 5; w++) drive_window(-1, 2048, 1'b0);

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
